vram_bus_arbiter: RTL

Arbitrates the single asynchronous VRAM bus between three requesters: video scanout fetch, ISA read, and the write-buffer drain. It replaces the fixed `free` tie-off on the write buffer. It sequences VRAM control strobes, address muxing and data latching, so requesters see a simple req/ack handshake. It sits between the ISA front end, the scanout pipeline and the VRAM pins.

---
 rtl/vram_pkg.sv | 31 +++
 rtl/vram_read_timer.sv | 40 ++++
 rtl/vram_bus_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// ============================================================================
// vram_pkg: shared types and constants for the VRAM bus arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vram_pkg;

    localparam int VRAM_AW = 20;
    localparam int VRAM_DW = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCAN_RD = 3'd1,
        ST_ISA_RD  = 3'd2,
        ST_WB_GNT  = 3'd3,
        ST_WB_XFER = 3'd4
    } arb_state_e;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};
    localparam strobes_t STROBES_READ = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1};

endpackage

`default_nettype wire

// File: rtl/vram_read_timer.sv
// ============================================================================
// vram_read_timer: loadable 3-bit down-counter timing a VRAM read strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vram_read_timer (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       load_i,
    input  logic [2:0] count_i,
    output logic       last_o,
    output logic       done_o
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = count_i;
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == 3'd1);
    assign done_o = (cnt_q == 3'd0);

endmodule

`default_nettype wire

// File: rtl/vram_bus_arbiter.sv
// ============================================================================
// vram_bus_arbiter: arbitrates the VRAM bus between scanout, ISA reads and
// the write-buffer drain. Optional macro: VRAM_ARB_STARVE_GUARD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vram_bus_arbiter
    import vram_pkg::*;
#(
    parameter int READ_CYCLES    = 2,
    parameter int SCAN_BURST_MAX = 8
) (
    input  logic               clock,
    input  logic               RESET,
    input  logic               scan_req,
    input  logic [VRAM_AW-1:0] scan_addr,
    output logic               scan_ack,
    input  logic               isa_rd_req,
    input  logic [VRAM_AW-1:0] isa_rd_addr,
    output logic               isa_rd_ack,
    output logic [VRAM_DW-1:0] rd_data,
    input  logic               wbuf_empty,
    input  logic               wbuf_almost_full,
    output logic               wbuf_free,
    input  logic [VRAM_AW-1:0] wbuf_addr,
    input  logic               wbuf_we_n,
    input  logic               wbuf_ce_n,
    input  logic               wbuf_io_en,
    input  logic [VRAM_DW-1:0] vram_data_in,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_ce_n,
    output logic               vram_oe_n,
    output logic               vram_we_n,
    output logic               busy
);

    localparam logic [2:0] READ_LOAD = 3'(READ_CYCLES);

    arb_state_e         state_q, state_d;
    strobes_t           strb_q, strb_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic [VRAM_DW-1:0] rd_data_q, rd_data_d;
    logic               scan_ack_q, scan_ack_d;
    logic               isa_ack_q, isa_ack_d;
    logic               free_q, free_d;
    logic               busy_q;
    logic               tmr_load, tmr_last, tmr_done;
    logic               wb_first;

    vram_read_timer u_timer (
        .clk_i   (clock),
        .rst_n_i (RESET),
        .load_i  (tmr_load),
        .count_i (READ_LOAD),
        .last_o  (tmr_last),
        .done_o  (tmr_done)
    );

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] BURST_MAX = 4'(SCAN_BURST_MAX);

    logic [3:0] burst_q, burst_d;

    assign wb_first = !wbuf_empty && (wbuf_almost_full || (burst_q >= BURST_MAX));

    // Only scan grants taken while writes are waiting count toward starvation.
    always_comb begin
        burst_d = burst_q;
        if (state_q == ST_IDLE && state_d == ST_WB_GNT) begin
            burst_d = 4'd0;
        end else if (state_q == ST_IDLE && state_d == ST_SCAN_RD &&
                     !wbuf_empty && burst_q != 4'hF) begin
            burst_d = burst_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!RESET) begin
            burst_q <= 4'd0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    logic unused_guard;
    assign unused_guard = wbuf_almost_full ^ (SCAN_BURST_MAX == 0);
    assign wb_first     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        strb_d     = STROBES_IDLE;
        addr_d     = addr_q;
        rd_data_d  = rd_data_q;
        scan_ack_d = 1'b0;
        isa_ack_d  = 1'b0;
        free_d     = 1'b0;
        tmr_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // ISA reads wait for an empty buffer so they see the latest writes.
                if (wb_first) begin
                    state_d = ST_WB_GNT;
                    free_d  = 1'b1;
                end else if (scan_req) begin
                    state_d  = ST_SCAN_RD;
                    addr_d   = scan_addr;
                    strb_d   = STROBES_READ;
                    tmr_load = 1'b1;
                end else if (isa_rd_req && wbuf_empty) begin
                    state_d  = ST_ISA_RD;
                    addr_d   = isa_rd_addr;
                    strb_d   = STROBES_READ;
                    tmr_load = 1'b1;
                end else if (!wbuf_empty) begin
                    state_d = ST_WB_GNT;
                    free_d  = 1'b1;
                end
            end
            ST_SCAN_RD, ST_ISA_RD: begin
                if (tmr_last) begin
                    state_d    = ST_IDLE;
                    rd_data_d  = vram_data_in;
                    scan_ack_d = (state_q == ST_SCAN_RD);
                    isa_ack_d  = (state_q == ST_ISA_RD);
                end else if (tmr_done) begin
                    state_d = ST_IDLE;
                end else begin
                    strb_d = STROBES_READ;
                end
            end
            ST_WB_GNT: begin
                // The buffer answers the grant this cycle; its strobes drive the next.
                state_d = ST_WB_XFER;
                addr_d  = wbuf_addr;
                if (wbuf_io_en) begin
                    strb_d = '{ce_n: wbuf_ce_n, oe_n: 1'b1, we_n: wbuf_we_n};
                end
            end
            ST_WB_XFER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            strb_q     <= STROBES_IDLE;
            addr_q     <= '0;
            rd_data_q  <= '0;
            scan_ack_q <= 1'b0;
            isa_ack_q  <= 1'b0;
            free_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            strb_q     <= strb_d;
            addr_q     <= addr_d;
            rd_data_q  <= rd_data_d;
            scan_ack_q <= scan_ack_d;
            isa_ack_q  <= isa_ack_d;
            free_q     <= free_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign scan_ack   = scan_ack_q;
    assign isa_rd_ack = isa_ack_q;
    assign rd_data    = rd_data_q;
    assign wbuf_free  = free_q;
    assign vram_addr  = addr_q;
    assign vram_ce_n  = strb_q.ce_n;
    assign vram_oe_n  = strb_q.oe_n;
    assign vram_we_n  = strb_q.we_n;
    assign busy       = busy_q;

endmodule

`default_nettype wire
